// File: rtl/branch_target_pipe_pkg.sv
// Shared definitions for the EX-stage branch target pipeline: mode encodings
// and default datapath widths.
package branch_target_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IMM_W_DEF  = 16;
    localparam int JIDX_W_DEF = 26;
    localparam int SHIFT_DEF  = 2;

    typedef enum logic [1:0] {
        MODE_BRANCH = 2'b00,
        MODE_JUMP   = 2'b01,
        MODE_SEQ    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

endpackage

// File: rtl/branch_target_pipe_stage_reg.sv
// One pipeline register holding {valid, target, wrap}. It has stall, flush
// and asynchronous active-low reset. Flush takes priority over stall.
module branch_target_pipe_stage_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] target_in,
    input  logic              wrap_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] target_out,
    output logic              wrap_out
);

    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              wrap_q,   wrap_d;

    // Next state: flush kills the valid bit, stall holds, otherwise capture.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        wrap_d   = wrap_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d  = valid_in;
            target_d = target_in;
            wrap_d   = wrap_in;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            target_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
            wrap_q   <= wrap_d;
        end
    end

    assign valid_out  = valid_q;
    assign target_out = target_q;
    assign wrap_out   = wrap_q;

endmodule

// File: rtl/branch_target_pipe.sv
// Pipelined next-fetch target generator. It handles PC-relative branches,
// pseudo-direct jumps and sequential flow. Stage-0 arithmetic is
// combinational. It feeds STAGES registers, and the outputs come straight
// from the last of those registers.
module branch_target_pipe
    import branch_target_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int JIDX_W = JIDX_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        mode_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [JIDX_W-1:0] jidx_in,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] target,
    output logic              wrap
);

    // PC bits above the jump field survive a pseudo-direct jump.
    localparam logic [DATA_W-1:0] HI_MASK = {DATA_W{1'b1}} << (JIDX_W + SHIFT);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("branch_target_pipe: STAGES must be in 1..4");
    end

    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] jfield;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] s0_target;
    logic              s0_wrap;

    // Stage-0 target selection and branch wrap detection.
    always_comb begin
        offset    = DATA_W'($signed(imm_in)) << SHIFT;
        jfield    = DATA_W'(jidx_in) << SHIFT;
        sum       = {1'b0, pc_in} + {1'b0, offset};
        s0_target = pc_in;
        s0_wrap   = 1'b0;
        case (mode_e'(mode_in))
            MODE_BRANCH: begin
                s0_target = sum[DATA_W-1:0];
                // A negative offset wraps when the result lands above pc_in.
                // A non-negative offset wraps when the add carries out.
                s0_wrap   = imm_in[IMM_W-1] ? (sum[DATA_W-1:0] > pc_in) : sum[DATA_W];
            end
            MODE_JUMP: begin
                s0_target = (pc_in & HI_MASK) | jfield;
            end
            default: begin
                s0_target = pc_in;
            end
        endcase
    end

    logic [STAGES:0]   v_chain;
    logic [STAGES:0]   w_chain;
    logic [DATA_W-1:0] t_chain [STAGES+1];

    assign v_chain[0] = in_valid;
    assign t_chain[0] = s0_target;
    assign w_chain[0] = s0_wrap;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        branch_target_pipe_stage_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk        (clk),
            .rst_n      (rst_n),
            .stall      (stall),
            .flush      (flush),
            .valid_in   (v_chain[i]),
            .target_in  (t_chain[i]),
            .wrap_in    (w_chain[i]),
            .valid_out  (v_chain[i+1]),
            .target_out (t_chain[i+1]),
            .wrap_out   (w_chain[i+1])
        );
    end

    assign out_valid = v_chain[STAGES];
    assign target    = t_chain[STAGES];
    assign wrap      = w_chain[STAGES];

endmodule

// File: tb/tb_branch_target_pipe.sv
// Bench for branch_target_pipe. It drives two instances (STAGES=1 and
// STAGES=3) in parallel. Each instance is checked against a signed-arithmetic
// reference model with a per-instance in-flight array.
module tb_branch_target_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  mode_in;
    logic [31:0] pc_in;
    logic [15:0] imm_in;
    logic [25:0] jidx_in;
    logic        stall;
    logic        flush;

    logic [1:0]  ov;
    logic [1:0]  ow;
    logic [31:0] ot [2];

    int tests = 0;
    int fails = 0;

    int   depth [2] = '{1, 3};
    logic        mv [2][4];
    logic [31:0] mt [2][4];
    logic        mw [2][4];

    branch_target_pipe #(.DATA_W(32), .IMM_W(16), .JIDX_W(26), .SHIFT(2), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode_in(mode_in), .pc_in(pc_in),
        .imm_in(imm_in), .jidx_in(jidx_in), .stall(stall), .flush(flush),
        .out_valid(ov[0]), .target(ot[0]), .wrap(ow[0])
    );

    branch_target_pipe #(.DATA_W(32), .IMM_W(16), .JIDX_W(26), .SHIFT(2), .STAGES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode_in(mode_in), .pc_in(pc_in),
        .imm_in(imm_in), .jidx_in(jidx_in), .stall(stall), .flush(flush),
        .out_valid(ov[1]), .target(ot[1]), .wrap(ow[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference target: {wrap, target}, computed with wide signed arithmetic.
    function automatic logic [32:0] ref_calc(input logic [1:0] m, input logic [31:0] pc,
                                             input logic [15:0] imm, input logic [25:0] j);
        longint s;
        logic [32:0] r;
        case (m)
            2'b00: begin
                s = longint'(pc) + longint'($signed(imm)) * 4;
                r = {(s < 0 || s > 64'sh0_FFFF_FFFF), s[31:0]};
            end
            2'b01:   r = {1'b0, pc[31:28], j, 2'b00};
            default: r = {1'b0, pc};
        endcase
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                mv[k][i] = 1'b0;
                mt[k][i] = '0;
                mw[k][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        logic [32:0] r;
        r = ref_calc(mode_in, pc_in, imm_in, jidx_in);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    for (int i = 0; i < 4; i++) mv[k][i] = 1'b0;
                end else if (!stall) begin
                    for (int i = depth[k] - 1; i > 0; i--) begin
                        mv[k][i] = mv[k][i-1];
                        mt[k][i] = mt[k][i-1];
                        mw[k][i] = mw[k][i-1];
                    end
                    mv[k][0] = in_valid;
                    mt[k][0] = r[31:0];
                    mw[k][0] = r[32];
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        int d;
        for (int k = 0; k < 2; k++) begin
            d = depth[k];
            cmp($sformatf("%s/s%0d/valid", tag, d), {31'b0, ov[k]}, {31'b0, mv[k][d-1]});
            if (mv[k][d-1]) begin
                cmp($sformatf("%s/s%0d/target", tag, d), ot[k], mt[k][d-1]);
                cmp($sformatf("%s/s%0d/wrap", tag, d), {31'b0, ow[k]}, {31'b0, mw[k][d-1]});
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("%s/%0d/valid", tag, k), {31'b0, ov[k]}, '0);
            cmp($sformatf("%s/%0d/target", tag, k), ot[k], '0);
            cmp($sformatf("%s/%0d/wrap", tag, k), {31'b0, ow[k]}, '0);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [25:0] j);
        in_valid = v;
        mode_in  = m;
        pc_in    = pc;
        imm_in   = imm;
        jidx_in  = j;
    endtask

    // Directed vector for the STAGES=1 instance: one edge, then known constants.
    task automatic vec1(input string tag, input logic [1:0] m, input logic [31:0] pc,
                        input logic [15:0] imm, input logic [25:0] j,
                        input logic [31:0] exp_t, input logic exp_w);
        drive(1'b1, m, pc, imm, j);
        step(tag);
        cmp({tag, "/const_valid"}, {31'b0, ov[0]}, 32'd1);
        cmp({tag, "/const_target"}, ot[0], exp_t);
        cmp({tag, "/const_wrap"}, {31'b0, ow[0]}, {31'b0, exp_w});
    endtask

    initial begin
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 2'b00, 32'h0040_0010, 16'h0004, '0);
        model_clear();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        for (int i = 0; i < 3; i++) begin
            step("reset_hold");
            check_zero("reset_hold");
        end
        // Deassert reset mid-cycle, then allow a few bubbles before traffic starts.
        #3 rst_n = 1'b1;
        drive(1'b0, 2'b00, '0, '0, '0);
        step("post_reset_idle");
        step("post_reset_idle");

        vec1("br_fwd",  2'b00, 32'h0040_0010, 16'h0004, '0, 32'h0040_0020, 1'b0);
        vec1("br_back", 2'b00, 32'h0040_0010, 16'hFFFC, '0, 32'h0040_0000, 1'b0);
        vec1("wrap_hi", 2'b00, 32'hFFFF_FFF0, 16'h0008, '0, 32'h0000_0010, 1'b1);
        vec1("wrap_lo", 2'b00, 32'h0000_0004, 16'hFFFE, '0, 32'hFFFF_FFFC, 1'b1);
        vec1("jump",    2'b01, 32'h8000_0004, 16'h0000, 26'h0100000, 32'h8040_0000, 1'b0);
        vec1("rsvd",    2'b11, 32'h0000_1234, 16'h0040, 26'h3FFFFFF, 32'h0000_1234, 1'b0);
        vec1("seq",     2'b10, 32'hDEAD_BEE0, 16'h8000, 26'h0000001, 32'hDEAD_BEE0, 1'b0);

        // Four back-to-back branches, with a two-cycle stall in the middle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 32'h0001_0000 + 32'(i) * 32'h100, 16'(i + 1), '0);
            step("b2b");
        end
        drive(1'b1, 2'b01, 32'hFFFF_FFFF, 16'h1234, 26'h2AAAAAA);
        stall = 1'b1;
        step("stall");
        step("stall");
        stall = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0);
        for (int i = 0; i < 4; i++) step("drain");

        // Flush together with stall while three entries are in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 32'h0200_0000, 16'(16'h0010 * (i + 1)), '0);
            step("pre_flush");
        end
        drive(1'b1, 2'b00, 32'h0300_0000, 16'h0020, '0);
        stall = 1'b1;
        flush = 1'b1;
        step("flush");
        cmp("flush/s3_killed", {31'b0, ov[1]}, '0);
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step("post_flush");
            cmp("post_flush/no_ghost", {30'b0, ov}, '0);
        end

        // Randomized traffic, including occasional stall, flush and near-wrap PCs.
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            mode_in  = 2'($urandom_range(0, 3));
            pc_in    = $urandom;
            case ($urandom_range(0, 3))
                0: pc_in = 32'hFFFF_0000 | 32'($urandom_range(0, 16'hFFFF));
                1: pc_in = 32'($urandom_range(0, 16'hFFFF));
                default: ;
            endcase
            imm_in  = 16'($urandom);
            jidx_in = 26'($urandom);
            stall   = ($urandom_range(0, 7) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            step("rand");
        end
        stall = 1'b0;
        flush = 1'b0;

        // Reset asserted mid-cycle with traffic in flight clears the outputs at once.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 32'h0500_0000, 16'(i + 7), '0);
            step("pre_rst");
        end
        #2 rst_n = 1'b0;
        #1 model_clear();
        check_zero("rst_mid_async");
        step("rst_mid_hold");
        check_zero("rst_mid_hold");
        #3 rst_n = 1'b1;
        drive(1'b0, 2'b00, '0, '0, '0);
        step("rst_recover_idle");
        drive(1'b1, 2'b00, 32'h0040_0010, 16'h0004, '0);
        step("rst_recover");
        drive(1'b0, 2'b00, '0, '0, '0);
        for (int i = 0; i < 3; i++) step("rst_recover");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
